key_direction_ctrl: RTL and testbench
=====================================

# key_direction_ctrl

Upstream input stage for the 2048 game controller. Takes the four raw, active-low, bouncing push-buttons and produces the clean one-hot `direction` word that the game control FSM samples. Each physical press yields exactly one move request. The request is held until the controller acknowledges it with its `update` pulse or a timeout expires. A further move is accepted only after every button has been released.

## Interface

Parameters:
- DB_COUNT, 50000 — debounce length in clock cycles; minimum 2.
- DB_WIDTH, 16 — width of the debounce counters; must hold DB_COUNT-1.
- HOLD_CYCLES, 8 — maximum cycles a direction is presented without acknowledge; minimum 8, covering the controller's divide-by-4 state clock.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- keys_n  in  4  raw buttons, 0 = pressed, asynchronous. Bit 0 = left, 1 = right, 2 = down, 3 = up.
- update  in  1  controller load strobe; counts as acknowledge while HOLD.
- locked  in  1  1 = game start/ended; blocks move generation.
- direction  out  4  one-hot move request, same bit mapping as keys_n; 4'b0000 = none.
- dropped  out  1  one-cycle pulse when a debounced press is discarded.

## Operation

Reset (reset_n = 0 at a rising edge):
- direction = 0, dropped = 0, FSM = IDLE.
- Synchronizer flops = 4'b1111 (released); debounced state = all released.
- Debounce and hold counters = 0.

Synchronizer:
- Two-flop synchronizer per key.
- Inverted output `s[i]`: 1 = pressed.

Debounce, one counter per key:
- If s[i] equals stable[i], the counter clears to 0.
- If they differ and the counter equals DB_COUNT-1, stable[i] takes s[i] and the counter clears.
- Otherwise the counter increments.
- A glitch shorter than DB_COUNT cycles never changes stable[i].

Press event:
- ev[i] = stable[i] & ~stable_d[i] (rising edge of the debounced state).

Priority:
- When several ev bits are set in the same cycle, the lowest index wins: left > right > down > up.

FSM:
- IDLE: direction = 0. If any ev is set and locked = 0, load the one-hot winner into direction and go to HOLD. If any ev is set and locked = 1, pulse dropped and stay in IDLE.
- HOLD: direction is held constant and the hold counter increments each cycle.
  - If update = 1 or the hold counter reaches HOLD_CYCLES-1, clear direction and the counter, go to RELEASE.
  - If locked = 1, clear direction and go to RELEASE.
  - Any new ev pulses dropped.
- RELEASE: direction = 0. Any new ev pulses dropped. When every stable bit is 0, go to IDLE.

Fixed rules:
- direction is never non-one-hot.
- direction is never non-zero outside HOLD.

## Timing

- Press latency: if keys_n[i] is first sampled low at edge N and stays low, stable[i] rises at edge N+DB_COUNT+1, and direction[i] = 1 after edge N+DB_COUNT+2.
- Release latency: the same figure applies to a release; RELEASE exits at the edge after stable goes all-zero.
- Acknowledge: with update = 1 sampled at HOLD edge M, direction = 0 after edge M. An update already present on HOLD entry is not seen until the next edge.
- Timeout: with no update, direction stays high for exactly HOLD_CYCLES cycles.
- dropped: high for exactly one cycle, the cycle following the ev sampling edge.
- Simultaneous events:
  - update together with timeout counts as one exit.
  - locked together with ev in IDLE: the event is dropped.
  - Reset mid-HOLD: direction = 0 after that edge, with no pulse on dropped.

## Test plan

All scenarios use DB_COUNT = 4 and HOLD_CYCLES = 8.

- Clean press: keys_n = 4'b1101 from edge 10, held. Required: direction = 4'b0010 after edge 16. update pulse at edge 20 gives direction = 0 after edge 20, FSM in RELEASE. Release keys: FSM returns to IDLE 6 edges after release is first sampled.
- Bounce rejection: keys_n[0] toggles low/high every 2 cycles for 20 cycles, then returns high. Required: direction stays 0 and dropped stays 0 throughout.
- Timeout: press up, never pulse update. Required: direction = 4'b1000 for exactly 8 cycles, then 0. A second up press before release produces no new request.
- Priority and drops: keys_n[0] and keys_n[3] fall on the same edge. Required: direction = 4'b0001 only. Pressing down during HOLD gives dropped = 1 for exactly one cycle.
- Lock: locked = 1, press right. Required: dropped pulses once and direction stays 0. Asserting locked mid-HOLD clears direction at the next edge.
- Reset: assert reset_n = 0 for one edge during HOLD. Required: direction = 0 and dropped = 0 after that edge. A key still held then yields a new request DB_COUNT+2 edges after reset release.

Source files
------------

// File: rtl/key_direction_ctrl.sv
// -----------------------------------------------------------------------------
// key_direction_ctrl
//
// Input stage for the 2048 game controller. Turns four raw, bouncing,
// active-low push-buttons into a clean one-hot move request that the game
// control FSM samples. Each physical press produces exactly one request. The
// request is held until the controller acknowledges it or a timeout expires.
// A new move is only accepted once every button has been released again.
//
// Parameters:
//   DB_COUNT     debounce length in clock cycles (>= 2)
//   DB_WIDTH     width of each debounce counter (must hold DB_COUNT-1)
//   HOLD_CYCLES  max cycles a direction is presented without acknowledge (>= 8)
//
// Ports:
//   clock      system clock, rising edge
//   reset_n    synchronous active-low reset
//   keys_n     raw buttons, 0 = pressed; bit 0 left, 1 right, 2 down, 3 up
//   update     controller load strobe, acts as acknowledge while holding
//   locked     game start/ended; blocks move generation
//   direction  one-hot move request (same bit mapping as keys_n), 0 = none
//   dropped    one-cycle pulse when a debounced press is discarded
// -----------------------------------------------------------------------------
module key_direction_ctrl #(
  parameter int DB_COUNT    = 50000,
  parameter int DB_WIDTH    = 16,
  parameter int HOLD_CYCLES = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] keys_n,
  input  logic       update,
  input  logic       locked,
  output logic [3:0] direction,
  output logic       dropped
);

  localparam int                  HOLD_W    = $clog2(HOLD_CYCLES);
  localparam logic [DB_WIDTH-1:0] DB_LAST   = DB_WIDTH'(DB_COUNT - 1);
  localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  logic [3:0]          syncMeta_q;
  logic [3:0]          sync_q;
  logic [3:0]          pressed;
  logic [DB_WIDTH-1:0] dbCnt_q [4];
  logic [DB_WIDTH-1:0] dbCnt_d [4];
  logic [3:0]          stable_q;
  logic [3:0]          stable_d;
  logic [3:0]          stablePrev_q;
  logic [3:0]          ev;
  logic [3:0]          winner;
  state_t              state_q;
  logic [HOLD_W-1:0]   holdCnt_q;
  logic [3:0]          direction_q;
  logic                dropped_q;

  // Two-flop synchronizer; resets to "all released" so a reset never looks
  // like a press.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      syncMeta_q <= 4'hF;
      sync_q     <= 4'hF;
    end else begin
      syncMeta_q <= keys_n;
      sync_q     <= syncMeta_q;
    end
  end

  assign pressed = ~sync_q;

  // Debounce: a key's stable state only flips after the synchronized level
  // has disagreed with it for DB_COUNT consecutive cycles; any agreement in
  // between restarts the count, so short glitches are ignored.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 4; i++) begin
      dbCnt_d[i] = dbCnt_q[i];
      if (pressed[i] == stable_q[i]) begin
        dbCnt_d[i] = '0;
      end else if (dbCnt_q[i] == DB_LAST) begin
        stable_d[i] = pressed[i];
        dbCnt_d[i]  = '0;
      end else begin
        dbCnt_d[i] = dbCnt_q[i] + DB_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        dbCnt_q[i] <= '0;
      end
      stable_q     <= 4'h0;
      stablePrev_q <= 4'h0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        dbCnt_q[i] <= dbCnt_d[i];
      end
      stable_q     <= stable_d;
      stablePrev_q <= stable_q;
    end
  end

  // Press events are rising edges of the debounced state.
  assign ev = stable_q & ~stablePrev_q;

  // x & -x isolates the lowest set bit, giving left > right > down > up.
  assign winner = ev & (~ev + 4'd1);

  // Request FSM with registered outputs. dropped defaults low every cycle so
  // it can only ever be a single-cycle pulse.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      holdCnt_q   <= '0;
      direction_q <= 4'h0;
      dropped_q   <= 1'b0;
    end else begin
      dropped_q <= 1'b0;
      case (state_q)
        IDLE: begin
          direction_q <= 4'h0;
          holdCnt_q   <= '0;
          if (|ev) begin
            if (locked) begin
              dropped_q <= 1'b1;
            end else begin
              direction_q <= winner;
              state_q     <= HOLD;
            end
          end
        end
        HOLD: begin
          dropped_q <= |ev;
          // Acknowledge, timeout and lock all end the request the same way,
          // so coincident causes collapse into one exit.
          if (update || (holdCnt_q == HOLD_LAST) || locked) begin
            direction_q <= 4'h0;
            holdCnt_q   <= '0;
            state_q     <= RELEASE;
          end else begin
            holdCnt_q <= holdCnt_q + HOLD_W'(1);
          end
        end
        RELEASE: begin
          direction_q <= 4'h0;
          holdCnt_q   <= '0;
          dropped_q   <= |ev;
          if (stable_q == 4'h0) begin
            state_q <= IDLE;
          end
        end
        default: begin
          direction_q <= 4'h0;
          holdCnt_q   <= '0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign direction = direction_q;
  assign dropped   = dropped_q;

endmodule

// File: tb/tb_key_direction_ctrl.sv
// -----------------------------------------------------------------------------
// tb_key_direction_ctrl
//
// Directed bench for key_direction_ctrl with DB_COUNT = 4 and
// HOLD_CYCLES = 8. Inputs change 1 time unit after a rising edge, so a new
// keys_n value is first sampled at the following edge. Outputs are sampled
// at the same point, i.e. just after the edge they reflect.
// -----------------------------------------------------------------------------
module tb_key_direction_ctrl;

  localparam int DB_COUNT    = 4;
  localparam int DB_WIDTH    = 16;
  localparam int HOLD_CYCLES = 8;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] keys_n;
  logic       update;
  logic       locked;
  logic [3:0] direction;
  logic       dropped;

  int checks   = 0;
  int failures = 0;

  key_direction_ctrl #(
    .DB_COUNT    (DB_COUNT),
    .DB_WIDTH    (DB_WIDTH),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .keys_n    (keys_n),
    .update    (update),
    .locked    (locked),
    .direction (direction),
    .dropped   (dropped)
  );

  always #5 clock = ~clock;

  // Single comparison point: counts and reports every check.
  task automatic checkOutput(input string tag, input logic [3:0] observed,
                             input logic [3:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  // Drive all control inputs at once.
  task automatic applyStimulus(input logic [3:0] keys, input logic upd,
                               input logic lck);
    keys_n = keys;
    update = upd;
    locked = lck;
  endtask

  // Advance n edges, then check both outputs just after the last edge.
  task automatic waitCheck(input int n, input string tag,
                           input logic [3:0] dirExp, input logic dropExp);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
    checkOutput({tag, "_dir"}, direction, dirExp);
    checkOutput({tag, "_drop"}, {3'b000, dropped}, {3'b000, dropExp});
  endtask

  initial begin
    reset_n = 1'b0;
    applyStimulus(4'b1111, 1'b0, 1'b0);
    waitCheck(2, "reset", 4'b0000, 1'b0);
    reset_n = 1'b1;

    // Clean press of right: first sampled at edge N, request after N+6.
    applyStimulus(4'b1101, 1'b0, 1'b0);
    waitCheck(6, "press_early", 4'b0000, 1'b0);
    waitCheck(1, "press_dir", 4'b0010, 1'b0);
    waitCheck(3, "press_hold", 4'b0010, 1'b0);
    applyStimulus(4'b1101, 1'b1, 1'b0);
    waitCheck(1, "ack_clear", 4'b0000, 1'b0);
    applyStimulus(4'b1101, 1'b0, 1'b0);
    waitCheck(5, "release_held", 4'b0000, 1'b0);
    applyStimulus(4'b1111, 1'b0, 1'b0);
    waitCheck(8, "released", 4'b0000, 1'b0);

    // Bounce on left: low/high every 2 cycles never reaches DB_COUNT.
    for (int k = 0; k < 10; k++) begin
      applyStimulus((k % 2 == 0) ? 4'b1110 : 4'b1111, 1'b0, 1'b0);
      waitCheck(2, "bounce", 4'b0000, 1'b0);
    end
    applyStimulus(4'b1111, 1'b0, 1'b0);
    waitCheck(6, "bounce_after", 4'b0000, 1'b0);

    // Timeout on up: exactly 8 cycles high with no acknowledge.
    applyStimulus(4'b0111, 1'b0, 1'b0);
    waitCheck(6, "up_early", 4'b0000, 1'b0);
    for (int k = 0; k < HOLD_CYCLES; k++) begin
      waitCheck(1, "timeout_hold", 4'b1000, 1'b0);
    end
    waitCheck(1, "timeout_clear", 4'b0000, 1'b0);
    // Keep right held, release and re-press up: presses in RELEASE only drop.
    applyStimulus(4'b0101, 1'b0, 1'b0);
    waitCheck(6, "right_pre", 4'b0000, 1'b0);
    waitCheck(1, "right_drop", 4'b0000, 1'b1);
    waitCheck(1, "right_drop_end", 4'b0000, 1'b0);
    applyStimulus(4'b1101, 1'b0, 1'b0);
    waitCheck(6, "up_released", 4'b0000, 1'b0);
    applyStimulus(4'b0101, 1'b0, 1'b0);
    waitCheck(6, "up_again_pre", 4'b0000, 1'b0);
    waitCheck(1, "up_again_drop", 4'b0000, 1'b1);
    waitCheck(1, "up_again_end", 4'b0000, 1'b0);
    applyStimulus(4'b1111, 1'b0, 1'b0);
    waitCheck(8, "timeout_released", 4'b0000, 1'b0);

    // Left and up together: left wins; down during HOLD drops once.
    applyStimulus(4'b0110, 1'b0, 1'b0);
    waitCheck(6, "prio_early", 4'b0000, 1'b0);
    waitCheck(1, "prio_dir", 4'b0001, 1'b0);
    applyStimulus(4'b0010, 1'b0, 1'b0);
    waitCheck(6, "prio_hold", 4'b0001, 1'b0);
    waitCheck(1, "hold_drop", 4'b0001, 1'b1);
    waitCheck(1, "hold_drop_end", 4'b0000, 1'b0);
    applyStimulus(4'b1111, 1'b0, 1'b0);
    waitCheck(8, "prio_released", 4'b0000, 1'b0);

    // Locked press of right is dropped.
    applyStimulus(4'b1101, 1'b0, 1'b1);
    waitCheck(6, "lock_early", 4'b0000, 1'b0);
    waitCheck(1, "lock_drop", 4'b0000, 1'b1);
    waitCheck(1, "lock_drop_end", 4'b0000, 1'b0);
    applyStimulus(4'b1111, 1'b0, 1'b1);
    waitCheck(8, "lock_released", 4'b0000, 1'b0);
    // Lock asserted mid-HOLD clears at the next edge.
    applyStimulus(4'b1101, 1'b0, 1'b0);
    waitCheck(6, "unlock_early", 4'b0000, 1'b0);
    waitCheck(1, "unlock_dir", 4'b0010, 1'b0);
    waitCheck(2, "unlock_hold", 4'b0010, 1'b0);
    applyStimulus(4'b1101, 1'b0, 1'b1);
    waitCheck(1, "lock_clear", 4'b0000, 1'b0);
    applyStimulus(4'b1111, 1'b0, 1'b0);
    waitCheck(8, "lock2_released", 4'b0000, 1'b0);

    // Reset mid-HOLD with left still held; re-request 7 edges after the
    // reset edge. Update raised before HOLD entry is only seen afterwards.
    applyStimulus(4'b1110, 1'b0, 1'b0);
    waitCheck(6, "rst_early", 4'b0000, 1'b0);
    waitCheck(1, "rst_pre", 4'b0001, 1'b0);
    reset_n = 1'b0;
    waitCheck(1, "rst_clear", 4'b0000, 1'b0);
    reset_n = 1'b1;
    waitCheck(6, "rst_rearm", 4'b0000, 1'b0);
    applyStimulus(4'b1110, 1'b1, 1'b0);
    waitCheck(1, "rst_request", 4'b0001, 1'b0);
    waitCheck(1, "entry_update", 4'b0000, 1'b0);
    applyStimulus(4'b1111, 1'b0, 1'b0);
    waitCheck(8, "final_idle", 4'b0000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
